// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA window pixel pipe: mode encoding,
// default RGB565 field widths, colour-bar table and the aligned flag bundle.
package vga_pkg;

  localparam int unsigned DEF_R_W = 5;
  localparam int unsigned DEF_G_W = 6;
  localparam int unsigned DEF_B_W = 5;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_H2X  = 2'd1,
    MODE_BARS = 2'd2,
    MODE_FILL = 2'd3
  } mode_e;

  localparam int unsigned BAR_CNT = 8;

  // {r,g,b} full-on flags per bar, left to right: white..black
  localparam logic [2:0] BAR_TABLE [BAR_CNT] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  typedef struct packed {
    mode_e      mode;
    logic       ready;
    logic       in_win;
    logic       rd;
    logic       phase;
    logic       empty_at_rd;
    logic [2:0] bar;
  } pix_flags_t;

  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/vga_window_pixel_pipe_if.sv
// Frame FIFO read port as seen by the pixel pipe (master) and the FIFO (slave).
interface vga_window_pixel_pipe_if #(
  parameter int unsigned PIX_W = 16
);
  logic             fifo_rd_en;
  logic [PIX_W-1:0] fifo_data;
  logic             fifo_empty;

  modport master (output fifo_rd_en, input fifo_data, input fifo_empty);
  modport slave  (input fifo_rd_en, output fifo_data, output fifo_empty);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset; aligns per-pixel flags with
// the FIFO read latency.
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  if (DEPTH == 1) begin : g_one
    always_comb stage_d = din;
  end else begin : g_many
    always_comb stage_d = {stage_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_window_pixel_pipe.sv
// VGA pixel output stage: windowed FIFO reads, read-latency alignment,
// 2x horizontal replication, colour bars, solid fill and underflow tracking.
module vga_window_pixel_pipe
  import vga_pkg::*;
#(
  parameter  int unsigned ADDR_W  = 11,
  parameter  int unsigned H_START = 1,
  parameter  int unsigned V_START = 50,
  parameter  int unsigned WIN_W   = 800,
  parameter  int unsigned WIN_H   = 480,
  parameter  int unsigned R_W     = DEF_R_W,
  parameter  int unsigned G_W     = DEF_G_W,
  parameter  int unsigned B_W     = DEF_B_W,
  parameter  int unsigned RD_LAT  = 1,
  localparam int unsigned PIX_W   = R_W + G_W + B_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Ready_Sig,
  input  logic [ADDR_W-1:0]       Column_Addr_Sig,
  input  logic [ADDR_W-1:0]       Row_Addr_Sig,
  input  logic [1:0]              mode,
  input  logic [PIX_W-1:0]        fill_color,
  vga_window_pixel_pipe_if.master fifo,
  input  logic                    underflow_clr,
  output logic [R_W-1:0]          Red_Sig,
  output logic [G_W-1:0]          Green_Sig,
  output logic [B_W-1:0]          Blue_Sig,
  output logic                    underflow,
  output logic                    frame_start
);

  localparam int unsigned BAR_LEN = WIN_W / 8;
  localparam int unsigned CNT_W   = $clog2(BAR_LEN + 1);
  localparam logic [ADDR_W-1:0] COL_LO = ADDR_W'(H_START);
  localparam logic [ADDR_W-1:0] COL_HI = ADDR_W'(H_START + WIN_W);
  localparam logic [ADDR_W-1:0] ROW_LO = ADDR_W'(V_START);
  localparam logic [ADDR_W-1:0] ROW_HI = ADDR_W'(V_START + WIN_H);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAR_LEN - 1);

  mode_e            mode_q, mode_d;
  logic             frame_start_q, frame_start_d;
  logic             phase_q, phase_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;

  logic             in_win_c, frame_c, rd_en_c, empty_at_rd_c;
  pix_flags_t       flags_c, flags_dl;
  logic [PIX_W-1:0] word_c, pix_c, bar_pix_c;
  logic [2:0]       bar_rgb_c;

  // Address stage: window decode, read strobe, mode shadow, phase and bar position
  always_comb begin
    in_win_c = Ready_Sig
            && (Column_Addr_Sig >= COL_LO) && (Column_Addr_Sig < COL_HI)
            && (Row_Addr_Sig >= ROW_LO)    && (Row_Addr_Sig < ROW_HI);
    frame_c  = Ready_Sig && (Column_Addr_Sig == '0) && (Row_Addr_Sig == '0);

    case (mode_q)
      MODE_PASS: rd_en_c = in_win_c;
      MODE_H2X:  rd_en_c = in_win_c && !phase_q;
      default:   rd_en_c = 1'b0;
    endcase
    rd_en_c       = rd_en_c && !RST;
    empty_at_rd_c = rd_en_c && fifo.fifo_empty;

    mode_d        = frame_c ? mode_e'(mode) : mode_q;
    frame_start_d = frame_c;
    phase_d       = in_win_c && !phase_q;
    // a new underflow in the same cycle as a clear keeps the flag set
    underflow_d   = empty_at_rd_c || (underflow_q && !underflow_clr);

    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (in_win_c) begin
      if (bar_cnt_q == CNT_LAST) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CNT_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end

    flags_c = '{mode: mode_q, ready: Ready_Sig, in_win: in_win_c, rd: rd_en_c,
                phase: phase_q, empty_at_rd: empty_at_rd_c, bar: bar_idx_q};
  end

  vga_delay_line #(
    .WIDTH ($bits(pix_flags_t)),
    .DEPTH (RD_LAT)
  ) u_flags_dl (
    .clk  (CLK),
    .rst  (RST),
    .din  (flags_c),
    .dout (flags_dl)
  );

  // Aligned stage: FIFO word (or fill on underflow), hold for the second 2x column
  always_comb begin
    word_c    = flags_dl.empty_at_rd ? fill_color : fifo.fifo_data;
    hold_d    = flags_dl.rd ? word_c : hold_q;
    bar_rgb_c = bar_flags(flags_dl.bar);
    bar_pix_c = {{R_W{bar_rgb_c[2]}}, {G_W{bar_rgb_c[1]}}, {B_W{bar_rgb_c[0]}}};

    case (flags_dl.mode)
      MODE_PASS: pix_c = word_c;
      MODE_H2X:  pix_c = flags_dl.phase ? hold_q : word_c;
      MODE_BARS: pix_c = bar_pix_c;
      default:   pix_c = fill_color;
    endcase

    rgb_d = (flags_dl.ready && flags_dl.in_win) ? pix_c : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q        <= MODE_PASS;
      frame_start_q <= 1'b0;
      phase_q       <= 1'b0;
      underflow_q   <= 1'b0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      hold_q        <= '0;
      rgb_q         <= '0;
    end else begin
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
      phase_q       <= phase_d;
      underflow_q   <= underflow_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      hold_q        <= hold_d;
      rgb_q         <= rgb_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en_c;
  assign Red_Sig         = rgb_q[PIX_W-1 -: R_W];
  assign Green_Sig       = rgb_q[B_W +: G_W];
  assign Blue_Sig        = rgb_q[B_W-1:0];
  assign underflow       = underflow_q;
  assign frame_start     = frame_start_q;

endmodule

// File: doc/vga_window_pixel_pipe.md
# vga_window_pixel_pipe

Parametrised VGA pixel output stage; successor to the fixed 800x480 RGB565 window controller. It sits between the VGA sync/timing generator (which supplies `Ready_Sig` and column/row addresses) and the frame FIFO. It issues FIFO reads for a configurable active window and aligns returned data to the pixel pipeline for a configurable FIFO read latency. It adds horizontal 2x pixel replication, built-in colour-bar and solid-fill modes, frame-synchronous mode switching, and FIFO underflow detection.

## Interface
Parameters:
- `ADDR_W`, default 11: width of column/row address inputs.
- `H_START`, default 1: first in-window column (inclusive).
- `V_START`, default 50: first in-window row (inclusive).
- `WIN_W`, default 800: window width in output pixels. Must be a multiple of 8.
- `WIN_H`, default 480: window height in rows.
- `R_W` / `G_W` / `B_W`, default 5 / 6 / 5: colour field widths. `PIX_W = R_W+G_W+B_W`.
- `RD_LAT`, default 1, legal 1..4: FIFO cycles from `fifo_rd_en` to valid `fifo_data`.

Ports:
- `CLK` in 1: pixel clock; the only clock.
- `RST` in 1: asynchronous, active-high reset.
- `Ready_Sig` in 1: timing generator is in the visible region.
- `Column_Addr_Sig` in `ADDR_W`: current column.
- `Row_Addr_Sig` in `ADDR_W`: current row.
- `mode` in 2: 0 pass-through, 1 horizontal 2x, 2 colour bars, 3 solid fill.
- `fill_color` in `PIX_W`: colour for mode 3 and for underflow substitution.
- `fifo_data` in `PIX_W`: FIFO read data, packed {R,G,B}.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO read strobe.
- `underflow_clr` in 1: clears `underflow`.
- `Red_Sig` out `R_W`: red output.
- `Green_Sig` out `G_W`: green output.
- `Blue_Sig` out `B_W`: blue output.
- `underflow` out 1: sticky underflow flag.
- `frame_start` out 1: one-cycle pulse when the new mode is latched.

## Operation
- `in_win` is true when `Ready_Sig` is high and `H_START <= col < H_START+WIN_W` and `V_START <= row < V_START+WIN_H`. The comparison is registered-free and computed on the current address.
- **Mode shadow.** `mode` is latched into `mode_q` only when `Ready_Sig && row==0 && col==0`. `frame_start` pulses in the same cycle. A mid-frame change of `mode` has no effect until the next frame.
- **FIFO reads:**
  - Mode 0: `fifo_rd_en = in_win`.
  - Mode 1: `fifo_rd_en = in_win && phase==0`. `phase` is a 1-bit toggle, cleared when `in_win` is low. It flips on every in-window pixel, so each FIFO word is shown on two adjacent columns and `WIN_W/2` words are consumed per line.
  - Modes 2 and 3: `fifo_rd_en = 0`.
- **Delay line.** `in_win`, `Ready_Sig`, `rd` (= `fifo_rd_en`), `phase` and `empty_at_rd` (= `fifo_rd_en && fifo_empty`) pass through an `RD_LAT`-deep shift register so they align with `fifo_data`.
- **Hold register.** When the delayed `rd` is set, the hold register captures `fifo_data`, or `fill_color` if the delayed `empty_at_rd` is set. In mode 1, the second (phase=1) column outputs the hold register.
- **Colour bars.** A bar counter resets at the window left edge and advances every `WIN_W/8` pixels (no divider). It selects one of 8 package constants: white, yellow, cyan, green, magenta, red, blue, black, left to right.
- **Output register.** Selected by delayed `Ready_Sig` && delayed `in_win`; otherwise 0.
- **Underflow.**
  - `underflow` sets on any `fifo_rd_en && fifo_empty`.
  - It clears on `underflow_clr`. If set and clear occur in the same cycle, set wins.

## Timing
- RGB outputs are registered. RGB for address (c, r) appears `RD_LAT+1` cycles after that address is presented, in every mode; the generated modes are delayed to match.
- `fifo_rd_en` is combinational from the current address, `Ready_Sig` and `mode_q`.
- Reset values: all RGB outputs 0, `fifo_rd_en` 0, `underflow` 0, `frame_start` 0, `mode_q` 0, `phase` 0, all delay-line stages 0, hold register 0.
- `Ready_Sig` dropping mid-window: no reads that cycle, `phase` clears, and the output is black `RD_LAT+1` cycles later.
- Reset asserted mid-line: everything clears immediately. Reads resume at the next in-window address with `phase` 0.

## Structure
- Package `vga_pkg`: mode encoding constants, RGB565 default field widths, and the 8-entry colour-bar constant table.
- Sub-module `vga_delay_line`: parametrised width/depth shift register with asynchronous reset, used for the aligned flags.

## Test plan
- **Mode 0, `RD_LAT`=1, defaults, FIFO data = column index:**
  - (c=1, r=50) produces `fifo_rd_en`=1.
  - RGB equals word 0 two cycles later.
  - 800 reads per line; (c=801) produces no read and black output.
- **Mode 1:** 400 reads per line on even window pixels. Output sequence is A, A, B, B…; the last column shows word 399 twice.
- **Mode 2:** no reads. Columns 1–100 are white (16'hFFFF) and columns 701–800 are black, each appearing with latency `RD_LAT+1`.
- **Mode change:** change `mode` 0→3 at row 200. Output stays pass-through until row 0/col 0, where `frame_start` pulses, then `fill_color` is shown in the window.
- **Underflow:** `fifo_empty`=1 at one in-window read. That pixel shows `fill_color` and `underflow`=1. `underflow_clr` in the same cycle as a new underflow leaves it at 1; a lone clear gives 0.
- **Reset:** `RST` pulsed at mid-line with `RD_LAT`=4. All outputs are 0 asynchronously, and the pipeline is flushed so no stale pixel appears after release.
